is_array_ctrl: RTL and testbench

- Sequencer for an input-stationary ROWS x COLS MAC array.
- Loads one stationary input tile into the array (input_en phase), then streams num_vecs weight vectors with process_en, including skew fill and drain.
- Drives read/write indices for the external input, weight and psum buffers, and signals completion.
- Sits between the top-level command interface and the PE grid plus its skew buffers.

---
 rtl/is_array_ctrl.sv | 139 +++++++++++++
 tb/tb_is_array_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/is_array_ctrl.sv
// Sequencer for an input-stationary ROWS x COLS MAC array: loads one input tile,
// then streams num_vecs weight vectors through the grid including skew fill/drain.
module is_array_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int CNT_W = 16,
  parameter int ROW_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vecs,
  input  logic             stall,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             input_en,
  output logic [ROW_W-1:0] load_idx,
  output logic             process_en,
  output logic             weight_rd_en,
  output logic [CNT_W-1:0] weight_rd_addr,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DONE
  } state_t;

  localparam logic [ROW_W-1:0] LOAD_LAST = ROW_W'(ROWS - 1);
  localparam logic [CNT_W:0]   ROWS_T    = (CNT_W+1)'(ROWS);
  localparam logic [CNT_W:0]   LAST_OFS  = (CNT_W+1)'(ROWS + COLS - 2);
  localparam logic [CNT_W:0]   OUT_OFS   = (CNT_W+1)'(ROWS + COLS - 1);
  localparam logic [CNT_W:0]   ONE_T     = (CNT_W+1)'(1);

  state_t           state, state_nx;
  logic [ROW_W-1:0] lcnt, lcnt_nx;
  logic [CNT_W:0]   t, t_nx;
  logic [CNT_W-1:0] nv, nv_nx;
  logic             err_q, err_nx;

  // One extra bit on t and its bounds keeps T = nv+ROWS+COLS-1 from wrapping.
  logic [CNT_W:0] nv_t, t_last, out_end, t_ofs;
  assign nv_t    = {1'b0, nv};
  assign t_last  = nv_t + LAST_OFS;
  assign out_end = nv_t + OUT_OFS;
  assign t_ofs   = t - ROWS_T;

  always_comb begin
    state_nx = state;
    lcnt_nx  = lcnt;
    t_nx     = t;
    nv_nx    = nv;
    err_nx   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (num_vecs != '0) begin
            nv_nx    = num_vecs;
            lcnt_nx  = '0;
            t_nx     = '0;
            state_nx = S_LOAD;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (lcnt == LOAD_LAST) begin
          lcnt_nx  = '0;
          t_nx     = '0;
          state_nx = S_COMPUTE;
        end else begin
          lcnt_nx = lcnt + 1'b1;
        end
      end
      S_COMPUTE: begin
        if (!stall) begin
          if (t == t_last) state_nx = S_DONE;
          else             t_nx     = t + ONE_T;
        end
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      state_nx = S_IDLE;
      lcnt_nx  = '0;
      t_nx     = '0;
      err_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      lcnt  <= '0;
      t     <= '0;
      nv    <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      lcnt  <= lcnt_nx;
      t     <= t_nx;
      nv    <= nv_nx;
      err_q <= err_nx;
    end
  end

  // Outputs decode registered state/counters; only stall acts combinationally.
  always_comb begin
    busy           = (state != S_IDLE);
    done           = (state == S_DONE);
    err            = err_q;
    input_en       = 1'b0;
    load_idx       = '0;
    process_en     = 1'b0;
    weight_rd_en   = 1'b0;
    weight_rd_addr = '0;
    out_valid      = 1'b0;
    out_idx        = '0;
    if (state == S_LOAD) begin
      input_en = 1'b1;
      load_idx = lcnt;
    end
    if (state == S_COMPUTE) begin
      process_en     = !stall;
      weight_rd_en   = !stall && (t < nv_t);
      weight_rd_addr = t[CNT_W-1:0];
      out_valid      = !stall && (t >= ROWS_T) && (t < out_end);
      if (t >= ROWS_T) out_idx = t_ofs[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_is_array_ctrl.sv
// Randomized bench for is_array_ctrl: per-run expected output traces are built
// from the phase rules (load rows, indexed compute steps, stall bubbles, done).
module tb_is_array_ctrl;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int CNT_W = 16;
  localparam int ROW_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_vecs;
  logic             stall;
  logic             abort;
  logic             busy, done, err, input_en, process_en, weight_rd_en, out_valid;
  logic [ROW_W-1:0] load_idx;
  logic [CNT_W-1:0] weight_rd_addr, out_idx;

  is_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vecs(num_vecs), .stall(stall),
    .abort(abort), .busy(busy), .done(done), .err(err), .input_en(input_en),
    .load_idx(load_idx), .process_en(process_en), .weight_rd_en(weight_rd_en),
    .weight_rd_addr(weight_rd_addr), .out_valid(out_valid), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             busy, done, err, input_en;
    logic [ROW_W-1:0] load_idx;
    logic             process_en, weight_rd_en;
    logic [CNT_W-1:0] waddr;
    logic             out_valid;
    logic [CNT_W-1:0] oidx;
    logic             chk_oidx;
    logic             stall;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] obs_v(input bit mask_oidx);
    return 64'({busy, done, err, input_en, load_idx, process_en, weight_rd_en,
                weight_rd_addr, out_valid, mask_oidx ? '0 : out_idx});
  endfunction

  function automatic logic [63:0] exp_v(input exp_t e);
    return 64'({e.busy, e.done, e.err, e.input_en, e.load_idx, e.process_en, e.weight_rd_en,
                e.waddr, e.out_valid, e.chk_oidx ? e.oidx : '0});
  endfunction

  // Expected trace: ROWS load cycles, then compute steps k=0..T-1 where a stalled
  // cycle is a bubble that repeats k, then one done cycle.
  task automatic build(input int nv, input logic [63:0] smask, input bit rnd, input int pct);
    exp_t e;
    int   k, c, tt;
    bit   s;
    q.delete();
    for (int i = 0; i < ROWS; i++) begin
      e          = '0;
      e.busy     = 1'b1;
      e.input_en = 1'b1;
      e.load_idx = ROW_W'(i);
      e.stall    = rnd ? ($urandom_range(0, 99) < pct) : 1'b0;
      q.push_back(e);
    end
    tt = nv + ROWS + COLS - 1;
    k  = 0;
    c  = 0;
    while (k < tt) begin
      s              = rnd ? ($urandom_range(0, 99) < pct) : (c < 64 && smask[c]);
      e              = '0;
      e.busy         = 1'b1;
      e.stall        = s;
      e.process_en   = !s;
      e.weight_rd_en = !s && (k < nv);
      e.waddr        = CNT_W'(k);
      e.out_valid    = !s && (k >= ROWS) && (k < ROWS + nv + COLS - 1);
      e.chk_oidx     = (k >= ROWS);
      e.oidx         = CNT_W'(k - ROWS);
      q.push_back(e);
      if (!s) k++;
      c++;
    end
    e      = '0;
    e.busy = 1'b1;
    e.done = 1'b1;
    e.stall = rnd ? ($urandom_range(0, 1) == 1) : 1'b0;
    q.push_back(e);
  endtask

  task automatic run(input int nv, input logic [63:0] smask, input bit rnd, input int pct,
                     input int abort_at, input int rst_at, input bit extra, input bit abort_idle,
                     output int proc_n, output int comp_n, output int ov_n);
    build(nv, smask, rnd, pct);
    proc_n   = 0;
    comp_n   = 0;
    ov_n     = 0;
    start    = 1'b1;
    num_vecs = CNT_W'(nv);
    abort    = abort_idle;
    @(negedge clk);
    check("pre_start", obs_v(1'b0), 64'h0);
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      stall = q[i].stall;
      abort = (i == abort_at);
      rst_n = (i != rst_at);
      if (extra && i >= ROWS) begin
        start    = ($urandom_range(0, 3) == 0);
        num_vecs = CNT_W'($urandom_range(0, 20));
      end
      @(negedge clk);
      check($sformatf("cyc%0d", i), obs_v(!q[i].chk_oidx), exp_v(q[i]));
      if (process_en) proc_n++;
      if (out_valid) ov_n++;
      if (busy && !input_en && !done) comp_n++;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;
      stall = 1'b0;
      if (i == abort_at || i == rst_at) break;
    end
    @(negedge clk);
    check("idle_after", obs_v(1'b0), 64'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic err_case();
    exp_t e;
    start    = 1'b1;
    num_vecs = '0;
    @(negedge clk);
    check("err_pre", obs_v(1'b0), 64'h0);
    @(posedge clk);
    #1;
    start = 1'b0;
    e     = '0;
    e.err = 1'b1;
    @(negedge clk);
    check("err_pulse", obs_v(1'b0), exp_v(e));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("err_clear", obs_v(1'b0), 64'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p, c, o, nv, ab, rs;
    rst_n    = 1'b0;
    start    = 1'b0;
    num_vecs = '0;
    stall    = 1'b0;
    abort    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset", obs_v(1'b0), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run(3, 64'h0, 1'b0, 0, -1, -1, 1'b0, 1'b0, p, c, o);
    check("nv3_proc", 64'(p), 64'd10);
    check("nv3_ovalid", 64'(o), 64'd6);

    run(3, 64'hCC, 1'b0, 0, -1, -1, 1'b0, 1'b0, p, c, o);
    check("stall_proc", 64'(p), 64'd10);
    check("stall_comp_len", 64'(c), 64'd14);

    err_case();

    run(3, 64'h0, 1'b0, 0, -1, -1, 1'b1, 1'b0, p, c, o);
    check("restart_proc", 64'(p), 64'd10);

    run(3, 64'h0, 1'b0, 0, 2, -1, 1'b0, 1'b0, p, c, o);
    run(3, 64'h0, 1'b0, 0, -1, -1, 1'b0, 1'b0, p, c, o);
    check("post_abort_proc", 64'(p), 64'd10);

    run(5, 64'h0, 1'b0, 0, -1, ROWS + 3, 1'b0, 1'b0, p, c, o);

    run(1, 64'h0, 1'b0, 0, -1, -1, 1'b0, 1'b1, p, c, o);
    check("nv1_proc", 64'(p), 64'd8);
    check("nv1_ovalid", 64'(o), 64'd4);

    for (int r = 0; r < 30; r++) begin
      nv = $urandom_range(1, 12);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ROWS + COLS + nv) : -1;
      rs = ($urandom_range(0, 9) == 0) ? $urandom_range(0, ROWS + COLS + nv) : -1;
      run(nv, 64'h0, 1'b1, $urandom_range(0, 40), ab, rs, $urandom_range(0, 1) == 1,
          1'b0, p, c, o);
      if (ab < 0 && rs < 0) check("rnd_proc", 64'(p), 64'(nv + ROWS + COLS - 1));
      if ($urandom_range(0, 4) == 0) err_case();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
